// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the ball engine.
//   state_t        FSM state encodings (IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4)
//   DEF_H_ACTIVE   default visible width
//   DEF_V_ACTIVE   default visible height
//   DEF_BALL_SIZE  default ball edge length
//   SCORE_MAX      score saturation value
package pong_pkg;

    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_BALL_SIZE = 15;
    localparam int SCORE_MAX     = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

endpackage

// File: rtl/ball_axis_stepper.sv
// ball_axis_stepper: position and direction of one ball axis.
//   Ball_Clock  in   clock
//   Game_Reset  in   async active-high reset, loads LOAD_POS / LOAD_DIR
//   load        in   synchronous reload to LOAD_POS / LOAD_DIR
//   move        in   advance one step this cycle
//   step        in   pixels per move
//   hit         in   external bounce override (with move): pos=hit_pos, dir=decreasing
//   hit_pos     in   position applied on an override
//   pos         out  current position
//   dir         out  1 = increasing coordinate, 0 = decreasing
// Walls are 0 and MAX_POS; reaching either clamps and flips direction.
module ball_axis_stepper #(
    parameter logic [9:0] MAX_POS  = 10'd625,
    parameter logic [9:0] LOAD_POS = 10'd313,
    parameter logic       LOAD_DIR = 1'b1
) (
    input  logic       Ball_Clock,
    input  logic       Game_Reset,
    input  logic       load,
    input  logic       move,
    input  logic [2:0] step,
    input  logic       hit,
    input  logic [9:0] hit_pos,
    output logic [9:0] pos,
    output logic       dir
);

    logic [10:0] fwd;
    logic        at_max;
    logic        at_min;

    // 11-bit forward sum so a step past the wall never wraps
    assign fwd    = {1'b0, pos} + {8'd0, step};
    assign at_max = dir && (fwd >= {1'b0, MAX_POS});
    assign at_min = !dir && ({1'b0, pos} < {8'd0, step});

    always_ff @(posedge Ball_Clock or posedge Game_Reset) begin
        if (Game_Reset) begin
            pos <= LOAD_POS;
            dir <= LOAD_DIR;
        end else if (load) begin
            pos <= LOAD_POS;
            dir <= LOAD_DIR;
        end else if (move) begin
            if (hit) begin
                pos <= hit_pos;
                dir <= 1'b0;
            end else if (at_max) begin
                pos <= MAX_POS;
                dir <= 1'b0;
            end else if (at_min) begin
                pos <= 10'd0;
                dir <= 1'b1;
            end else if (dir) begin
                pos <= fwd[9:0];
            end else begin
                pos <= pos - {7'd0, step};
            end
        end
    end

endmodule

// File: rtl/ball_engine.sv
// ball_engine: ball position, score, lives and serve/play/miss/over flow.
//   Ball_Clock       in   system clock
//   Game_Reset       in   async active-high reset
//   tick             in   one-cycle move strobe per frame
//   start            in   level; starts a game from IDLE or OVER
//   speed            in   pixels per tick (0 treated as 1)
//   paddle_location  in   paddle left x
//   ball_x, ball_y   out  ball top-left corner
//   score_counter    out  paddle hits, saturating at SCORE_MAX
//   lives_left       out  remaining lives
//   bounce           out  one-cycle pulse per paddle hit
//   game_over        out  high in OVER
//   state            out  FSM state
// Build option BALL_SPEEDUP_EN: adds 1 to the step every 4 paddle hits
// (step saturates at 7); the boost clears on every serve.
module ball_engine import pong_pkg::*; #(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int BALL_SIZE   = DEF_BALL_SIZE,
    parameter int PADDLE_W    = 80,
    parameter int PADDLE_Y    = 451,
    parameter int SERVE_X     = 313,
    parameter int SERVE_Y     = 80,
    parameter int LIVES       = 3,
    parameter int SERVE_DELAY = 60
) (
    input  logic       Ball_Clock,
    input  logic       Game_Reset,
    input  logic       tick,
    input  logic       start,
    input  logic [2:0] speed,
    input  logic [9:0] paddle_location,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [7:0] score_counter,
    output logic [2:0] lives_left,
    output logic       bounce,
    output logic       game_over,
    output logic [2:0] state
);

    localparam logic [10:0] PAD_TOP = 11'(PADDLE_Y - BALL_SIZE);
    localparam logic [10:0] FLOOR   = 11'(V_ACTIVE - BALL_SIZE);

    state_t      st;
    logic [15:0] delay_cnt;
    logic [2:0]  base_step;
    logic [2:0]  step;
    logic        dir_down;
    logic        play_move;
    logic        paddle_hit;
    logic        miss_now;
    logic        serve_load;
    logic        serve_done;
    logic [10:0] y_fwd;

    assign base_step  = (speed == 3'd0) ? 3'd1 : speed;
    assign play_move  = (st == ST_PLAY) && tick;
    assign y_fwd      = {1'b0, ball_y} + {8'd0, step};

    assign paddle_hit = play_move && dir_down &&
                        (y_fwd >= PAD_TOP) &&
                        ({1'b0, ball_y} < PAD_TOP) &&
                        (({1'b0, ball_x} + 11'(BALL_SIZE)) > {1'b0, paddle_location}) &&
                        ({1'b0, ball_x} < ({1'b0, paddle_location} + 11'(PADDLE_W)));

    assign miss_now   = play_move && dir_down && !paddle_hit && (y_fwd >= FLOOR);

    // a new serve begins from IDLE/OVER on start, or after a non-final miss
    assign serve_load = (((st == ST_IDLE) || (st == ST_OVER)) && start) ||
                        ((st == ST_MISS) && (lives_left != 3'd1));
    assign serve_done = (st == ST_SERVE) && tick &&
                        ((delay_cnt + 16'd1) >= 16'(SERVE_DELAY));

`ifdef BALL_SPEEDUP_EN
    logic [1:0] hit_cnt;
    logic [2:0] boost;
    logic [3:0] step_sum;

    assign step_sum = {1'b0, base_step} + {1'b0, boost};
    assign step     = step_sum[3] ? 3'd7 : step_sum[2:0];

    always_ff @(posedge Ball_Clock or posedge Game_Reset) begin
        if (Game_Reset) begin
            hit_cnt <= 2'd0;
            boost   <= 3'd0;
        end else if (serve_load) begin
            hit_cnt <= 2'd0;
            boost   <= 3'd0;
        end else if (paddle_hit) begin
            hit_cnt <= hit_cnt + 2'd1;
            if ((hit_cnt == 2'd3) && (boost != 3'd7))
                boost <= boost + 3'd1;
        end
    end
`else
    assign step = base_step;
`endif

    ball_axis_stepper #(
        .MAX_POS  (10'(H_ACTIVE - BALL_SIZE)),
        .LOAD_POS (10'(SERVE_X)),
        .LOAD_DIR (1'b1)
    ) u_x (
        .Ball_Clock (Ball_Clock),
        .Game_Reset (Game_Reset),
        .load       (serve_load || serve_done),
        .move       (play_move),
        .step       (step),
        .hit        (1'b0),
        .hit_pos    (10'd0),
        .pos        (ball_x),
        .dir        ()
    );

    // y ceiling is the floor line; a miss clamps there and the FSM takes over
    ball_axis_stepper #(
        .MAX_POS  (10'(V_ACTIVE - BALL_SIZE)),
        .LOAD_POS (10'(SERVE_Y)),
        .LOAD_DIR (1'b0)
    ) u_y (
        .Ball_Clock (Ball_Clock),
        .Game_Reset (Game_Reset),
        .load       (serve_load || serve_done),
        .move       (play_move),
        .step       (step),
        .hit        (paddle_hit),
        .hit_pos    (PAD_TOP[9:0]),
        .pos        (ball_y),
        .dir        (dir_down)
    );

    always_ff @(posedge Ball_Clock or posedge Game_Reset) begin
        if (Game_Reset) begin
            st            <= ST_IDLE;
            delay_cnt     <= 16'd0;
            score_counter <= 8'd0;
            lives_left    <= 3'(LIVES);
            bounce        <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            bounce <= paddle_hit;
            case (st)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        st            <= ST_SERVE;
                        delay_cnt     <= 16'd0;
                        score_counter <= 8'd0;
                        lives_left    <= 3'(LIVES);
                        game_over     <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    if (serve_done) begin
                        st        <= ST_PLAY;
                        delay_cnt <= 16'd0;
                    end else if (tick) begin
                        delay_cnt <= delay_cnt + 16'd1;
                    end
                end
                ST_PLAY: begin
                    if (paddle_hit && (score_counter != 8'(SCORE_MAX)))
                        score_counter <= score_counter + 8'd1;
                    if (miss_now)
                        st <= ST_MISS;
                end
                ST_MISS: begin
                    lives_left <= lives_left - 3'd1;
                    if (lives_left == 3'd1) begin
                        st        <= ST_OVER;
                        game_over <= 1'b1;
                    end else begin
                        st        <= ST_SERVE;
                        delay_cnt <= 16'd0;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: randomized play against a behavioural game model with a
// per-cycle scoreboard, plus direct reset and serve checks.
`timescale 1ns/1ps
module tb_ball_engine;

    localparam int LIVES = 3;
    localparam int SERVE_DELAY = 60;
    localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_MISS = 3, P_OVER = 4;

    logic       Ball_Clock = 1'b0;
    logic       Game_Reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [2:0] speed = 3'd1;
    logic [9:0] paddle_location = 10'd0;
    logic [9:0] ball_x, ball_y;
    logic [7:0] score_counter;
    logic [2:0] lives_left;
    logic       bounce, game_over;
    logic [2:0] state;

    ball_engine dut (
        .Ball_Clock      (Ball_Clock),
        .Game_Reset      (Game_Reset),
        .tick            (tick),
        .start           (start),
        .speed           (speed),
        .paddle_location (paddle_location),
        .ball_x          (ball_x),
        .ball_y          (ball_y),
        .score_counter   (score_counter),
        .lives_left      (lives_left),
        .bounce          (bounce),
        .game_over       (game_over),
        .state           (state)
    );

    always #5 Ball_Clock = ~Ball_Clock;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] sc;
        logic [2:0] lv;
        logic       b;
        logic       go;
        logic [2:0] st;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // game model
    int m_phase, mx, my, m_score, m_lives, m_cnt, m_hits;
    bit m_right, m_down, m_bounce;

    task automatic new_serve();
        mx = 313; my = 80; m_right = 1; m_down = 0; m_cnt = 0; m_hits = 0;
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_score = 0; m_lives = LIVES; m_bounce = 0;
        new_serve();
    endtask

    task automatic model_step(bit t, bit s, int sp, int pad);
        int stp;
        m_bounce = 0;
        case (m_phase)
            P_IDLE, P_OVER: if (s) begin
                m_phase = P_SERVE; m_score = 0; m_lives = LIVES; new_serve();
            end
            P_SERVE: if (t) begin
                m_cnt++;
                if (m_cnt >= SERVE_DELAY) m_phase = P_PLAY;
            end
            P_PLAY: if (t) begin
                stp = (sp == 0) ? 1 : sp;
`ifdef BALL_SPEEDUP_EN
                stp = stp + m_hits / 4;
                if (stp > 7) stp = 7;
`endif
                if (m_down) begin
                    if (my + stp >= 436 && my < 436 && mx + 15 > pad && mx < pad + 80) begin
                        my = 436; m_down = 0; m_bounce = 1; m_hits++;
                        if (m_score < 255) m_score++;
                    end else if (my + stp >= 465) begin
                        my = 465; m_phase = P_MISS;
                    end else my += stp;
                end else if (my < stp) begin
                    my = 0; m_down = 1;
                end else my -= stp;
                if (m_right) begin
                    if (mx + stp >= 625) begin mx = 625; m_right = 0; end
                    else mx += stp;
                end else if (mx < stp) begin
                    mx = 0; m_right = 1;
                end else mx -= stp;
            end
            P_MISS: begin
                m_lives--;
                if (m_lives == 0) m_phase = P_OVER;
                else begin m_phase = P_SERVE; new_serve(); end
            end
            default: ;
        endcase
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.x = 10'(mx); o.y = 10'(my); o.sc = 8'(m_score); o.lv = 3'(m_lives);
        o.b = m_bounce; o.go = (m_phase == P_OVER); o.st = 3'(m_phase);
        return o;
    endfunction

    // drive one cycle of stimulus and queue the expected registered response
    task automatic cyc(bit t, bit s, int sp, int pad);
        @(negedge Ball_Clock);
        if (pad < 0) pad = 0;
        tick = t; start = s; speed = 3'(sp); paddle_location = 10'(pad);
        model_step(t, s, sp, pad);
        exp_q.push_back(model_obs());
    endtask

    task automatic chk(string nm, int got, int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d want %0d", nm, got, want);
    endtask

    task automatic chk_reset(string tag);
        chk({tag, " ball_x"}, int'(ball_x), 313);
        chk({tag, " ball_y"}, int'(ball_y), 80);
        chk({tag, " score"}, int'(score_counter), 0);
        chk({tag, " lives"}, int'(lives_left), LIVES);
        chk({tag, " bounce"}, int'(bounce), 0);
        chk({tag, " game_over"}, int'(game_over), 0);
        chk({tag, " state"}, int'(state), P_IDLE);
    endtask

    // monitor: compare every registered update against the queued expectation
    initial begin
        obs_t e, a;
        forever begin
            @(posedge Ball_Clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {ball_x, ball_y, score_counter, lives_left, bounce, game_over, state};
                checks++;
                if (a === e) passed++;
                else $display("FAIL cycle @%0t: got x=%0d y=%0d sc=%0d lv=%0d b=%0d go=%0d st=%0d want x=%0d y=%0d sc=%0d lv=%0d b=%0d go=%0d st=%0d",
                              $time, a.x, a.y, a.sc, a.lv, a.b, a.go, a.st,
                              e.x, e.y, e.sc, e.lv, e.b, e.go, e.st);
            end
        end
    end

    initial begin
        int extra;
        bit was_max;
        #12;
        chk_reset("init");
        @(negedge Ball_Clock);
        Game_Reset = 1'b0;
        model_reset();

        // idle, then serve delay and first motion tick
        repeat (3) cyc(1, 0, 1, 0);
        cyc(0, 1, 1, 0);
        repeat (SERVE_DELAY) cyc(1, 0, 1, 300);
        cyc(1, 0, 1, 300);
        @(posedge Ball_Clock); #2;
        chk("first ball_x", int'(ball_x), 314);
        chk("first ball_y", int'(ball_y), 79);
        chk("first state", int'(state), P_PLAY);

        // random play: mostly tracking paddle, sometimes a random one
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) != 0)
                cyc($urandom_range(0, 3) != 0, 0, $urandom_range(0, 7), mx - $urandom_range(0, 14));
            else
                cyc($urandom_range(0, 3) != 0, 0, $urandom_range(0, 7), $urandom_range(0, 560));
        end

        // paddle kept away from the ball until the game ends
        for (int i = 0; i < 6000 && m_phase != P_OVER; i++)
            cyc(1, 0, $urandom_range(0, 7), (mx < 300) ? 540 : 0);
        chk("reached OVER", m_phase, P_OVER);

        // ticks ignored while over, then restart
        repeat (20) cyc(1, 0, 5, 0);
        @(posedge Ball_Clock); #2;
        chk("over game_over", int'(game_over), 1);
        chk("over state", int'(state), P_OVER);
        cyc(0, 1, 1, 0);
        @(posedge Ball_Clock); #2;
        chk("restart score", int'(score_counter), 0);
        chk("restart lives", int'(lives_left), LIVES);
        chk("restart state", int'(state), P_SERVE);

        // score saturation: perfect paddle, fast ball, three hits past 255
        extra = 0;
        for (int i = 0; i < 45000 && extra < 3; i++) begin
            was_max = (m_score == 255);
            cyc(1, 0, 7, mx);
            if (was_max && m_bounce) extra++;
        end
        chk("hits past saturation", extra, 3);
        @(posedge Ball_Clock); #2;
        chk("saturated score", int'(score_counter), 255);

        // asynchronous reset between clock edges while playing
        @(negedge Ball_Clock);
        #3;
        Game_Reset = 1'b1;
        #1;
        chk_reset("async");
        model_reset();
        @(negedge Ball_Clock);
        @(negedge Ball_Clock);
        Game_Reset = 1'b0;
        repeat (4) cyc(1, 0, 3, 0);

        @(posedge Ball_Clock); #2;
        @(posedge Ball_Clock); #2;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
